mem_arbiter: RTL and testbench

Shares the single RAM port (address register AM plus RAM read/write strobes) of the didactic computer among `NREQ` requesters: the control unit's fetch/execute path, I/O and DMA-style masters. It arbitrates round-robin and runs each granted transaction through a fixed address/access/acknowledge sequence. It drives the same `am_we`/`ram_oe`/`ram_we` strobes the control unit would otherwise drive, and sits between the requesters and the RAM/AM pair.

---
 rtl/calc_defs.sv | 19 +
 rtl/rr_pick.sv | 36 +++
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_defs.sv
// Shared definitions for the RAM-port arbiter: FSM encoding, default widths and display helper.
// Defining MEM_ARB_LOCK_EN adds a per-requester lock input that chains back-to-back transactions.
package calc_defs;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ADDR   = 2'd1,
        ARB_ACCESS = 2'd2,
        ARB_DONE   = 2'd3
    } arbState_e;

    localparam int DEFAULT_WORD_WIDTH = 16;
    localparam int DISP_WIDTH         = 4;

    function automatic logic [DISP_WIDTH-1:0] dispCode(arbState_e s);
        return {2'b00, s};
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request at or after the pointer, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PtrW = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PtrW-1:0] ptr_i,
    output logic [NREQ-1:0] winner_o,
    output logic [PtrW-1:0] winIdx_o,
    output logic            valid_o
);

    // Walk the requesters starting at the pointer; the one extra bit of sum absorbs the wrap.
    always_comb begin
        logic [PtrW:0]   sum;
        logic [PtrW-1:0] cand;
        winner_o = '0;
        winIdx_o = '0;
        valid_o  = 1'b0;
        sum      = '0;
        cand     = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_i} + (PtrW+1)'(k);
            if (sum >= (PtrW+1)'(NREQ)) begin
                sum = sum - (PtrW+1)'(NREQ);
            end
            cand = sum[PtrW-1:0];
            if (!valid_o && req_i[cand]) begin
                valid_o        = 1'b1;
                winner_o[cand] = 1'b1;
                winIdx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the AM/RAM port among NREQ requesters (IDLE/ADDR/ACCESS/DONE).
// Optional MEM_ARB_LOCK_EN: a locked owner with a held request re-enters ADDR directly from DONE.
module mem_arbiter
    import calc_defs::*;
#(
    parameter int NREQ       = 4,
    parameter int word_width = DEFAULT_WORD_WIDTH
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NREQ-1:0]            req_i,
    input  logic [NREQ-1:0]            we_i,
    input  logic [NREQ*word_width-1:0] addr_i,
    input  logic [NREQ*word_width-1:0] wdata_i,
`ifdef MEM_ARB_LOCK_EN
    input  logic [NREQ-1:0]            lock_i,
`endif
    output logic [NREQ-1:0]            gnt_o,
    output logic [NREQ-1:0]            ack_o,
    output logic [word_width-1:0]      rdata_o,
    output logic [word_width-1:0]      mem_addr_o,
    output logic [word_width-1:0]      mem_wdata_o,
    input  logic [word_width-1:0]      mem_rdata_i,
    output logic                       am_we_o,
    output logic                       ram_oe_o,
    output logic                       ram_we_o,
    output logic                       busy_o,
    output logic [DISP_WIDTH-1:0]      disp_state_o
);

    localparam int PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arbState_e             state_q;
    logic [PtrW-1:0]       ptr_q;
    logic [PtrW-1:0]       owner_q;
    logic [NREQ-1:0]       gnt_q;
    logic [NREQ-1:0]       ack_q;
    logic                  weOwner_q;
    logic [word_width-1:0] rdata_q;
    logic [word_width-1:0] memAddr_q;
    logic [word_width-1:0] memWdata_q;
    logic                  amWe_q;
    logic                  ramOe_q;
    logic                  ramWe_q;

    logic [NREQ-1:0]       pickOneHot;
    logic [PtrW-1:0]       pickIdx;
    logic                  pickValid;
    logic [PtrW-1:0]       nextPtr;
    logic [word_width-1:0] addrArr  [NREQ];
    logic [word_width-1:0] wdataArr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : gUnpack
        assign addrArr[g]  = addr_i[g*word_width +: word_width];
        assign wdataArr[g] = wdata_i[g*word_width +: word_width];
    end

    rr_pick #(
        .NREQ (NREQ),
        .PtrW (PtrW)
    ) uPick (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .winner_o (pickOneHot),
        .winIdx_o (pickIdx),
        .valid_o  (pickValid)
    );

    assign nextPtr = (owner_q == PtrW'(NREQ-1)) ? '0 : owner_q + 1'b1;

    // Every output is a register set one state ahead, so nothing reaches the pins combinationally from req.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ARB_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            gnt_q      <= '0;
            ack_q      <= '0;
            weOwner_q  <= 1'b0;
            rdata_q    <= '0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            amWe_q     <= 1'b0;
            ramOe_q    <= 1'b0;
            ramWe_q    <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pickValid) begin
                        state_q   <= ARB_ADDR;
                        gnt_q     <= pickOneHot;
                        owner_q   <= pickIdx;
                        weOwner_q <= we_i[pickIdx];
                        amWe_q    <= 1'b1;
                        memAddr_q <= addrArr[pickIdx];
                    end
                end
                ARB_ADDR: begin
                    state_q   <= ARB_ACCESS;
                    amWe_q    <= 1'b0;
                    memAddr_q <= '0;
                    if (weOwner_q) begin
                        ramWe_q    <= 1'b1;
                        memWdata_q <= wdataArr[owner_q];
                    end else begin
                        ramOe_q <= 1'b1;
                    end
                end
                ARB_ACCESS: begin
                    state_q    <= ARB_DONE;
                    ramOe_q    <= 1'b0;
                    ramWe_q    <= 1'b0;
                    memWdata_q <= '0;
                    ack_q      <= gnt_q;
                    rdata_q    <= weOwner_q ? '0 : mem_rdata_i;
                end
                ARB_DONE: begin
                    ack_q   <= '0;
                    rdata_q <= '0;
`ifdef MEM_ARB_LOCK_EN
                    // A locked owner keeps the grant and the pointer; fairness resumes on the first unlocked DONE.
                    if (lock_i[owner_q] && req_i[owner_q]) begin
                        state_q   <= ARB_ADDR;
                        weOwner_q <= we_i[owner_q];
                        amWe_q    <= 1'b1;
                        memAddr_q <= addrArr[owner_q];
                    end else
`endif
                    begin
                        state_q <= ARB_IDLE;
                        gnt_q   <= '0;
                        ptr_q   <= nextPtr;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign gnt_o        = gnt_q;
    assign ack_o        = ack_q;
    assign rdata_o      = rdata_q;
    assign mem_addr_o   = memAddr_q;
    assign mem_wdata_o  = memWdata_q;
    assign am_we_o      = amWe_q;
    assign ram_oe_o     = ramOe_q;
    assign ram_we_o     = ramWe_q;
    assign busy_o       = (state_q != ARB_IDLE);
    assign disp_state_o = dispCode(state_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: randomized requesters, an AM register plus RAM model,
// and a transaction-level reference that predicts which requester is served and when.
module tb_mem_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 16;

    typedef struct {
        int         start;
        int         owner;
        logic       isWrite;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
    } txn_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   we = '0;
    logic [NREQ-1:0]   lock = '0;
    logic [NREQ*W-1:0] addrBus = '0;
    logic [NREQ*W-1:0] wdataBus = '0;

    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   ack;
    logic [W-1:0]      rdata;
    logic [W-1:0]      memAddr;
    logic [W-1:0]      memWdata;
    logic [W-1:0]      memRdata;
    logic              amWe;
    logic              ramOe;
    logic              ramWe;
    logic              busy;
    logic [3:0]        dispState;

    logic [W-1:0]      amReg;
    logic [W-1:0]      ram    [256];
    logic [W-1:0]      shadow [256];

    txn_t expQ[$];
    int   cyc = 0;
    int   nextFree = 0;
    int   modelPtr = 0;
    bit   sbEnable = 1'b1;
    bit   pending [NREQ];
    int   autoRate = 0;
    int   dropRate = 0;
    int   checkCount = 0;
    int   failCount = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .NREQ       (NREQ),
        .word_width (W)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .we_i         (we),
        .addr_i       (addrBus),
        .wdata_i      (wdataBus),
`ifdef MEM_ARB_LOCK_EN
        .lock_i       (lock),
`endif
        .gnt_o        (gnt),
        .ack_o        (ack),
        .rdata_o      (rdata),
        .mem_addr_o   (memAddr),
        .mem_wdata_o  (memWdata),
        .mem_rdata_i  (memRdata),
        .am_we_o      (amWe),
        .ram_oe_o     (ramOe),
        .ram_we_o     (ramWe),
        .busy_o       (busy),
        .disp_state_o (dispState)
    );

    // The AM register latches the address on am_we; the RAM reads combinationally from AM and writes on ram_we.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) amReg <= '0;
        else if (amWe) amReg <= memAddr;
    end

    always @(posedge clk) begin
        if (ramWe) ram[amReg[7:0]] <= memWdata;
    end

    assign memRdata = ram[amReg[7:0]];

    initial begin
        for (int a = 0; a < 256; a++) begin
            ram[a]    = 16'(a * 40503) ^ 16'h5A5A;
            shadow[a] = 16'(a * 40503) ^ 16'h5A5A;
        end
        ram[8'h12]    = 16'hBEEF;
        shadow[8'h12] = 16'hBEEF;
    end

    function automatic void checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at cycle %0d: got %h, required %h", name, cyc, actual, expected);
        end
    endfunction

    // Reference model: whenever the port is free, the first requester at or after the pointer is served,
    // finishing three cycles later; the port is free again one cycle after that.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                cyc      = 0;
                nextFree = 0;
                modelPtr = 0;
            end else begin
                cyc++;
                if (sbEnable && cyc >= nextFree && req != '0) begin
                    int win;
                    txn_t t;
                    win = -1;
                    for (int k = 0; k < NREQ; k++) begin
                        int c;
                        c = (modelPtr + k) % NREQ;
                        if (win < 0 && req[c]) win = c;
                    end
                    t.start   = cyc;
                    t.owner   = win;
                    t.isWrite = we[win];
                    t.addr    = addrBus[win*W +: W];
                    t.wdata   = wdataBus[win*W +: W];
                    expQ.push_back(t);
                    nextFree = cyc + 4;
                    modelPtr = (win + 1) % NREQ;
                end
            end
        end
    end

    // Monitor: compares the port outputs each cycle against the oldest predicted transaction.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                expQ.delete();
            end else if (sbEnable) begin
                logic [NREQ-1:0] gntE, ackE;
                logic            amWeE, ramOeE, ramWeE, busyE;
                logic [3:0]      dispE;
                logic [W-1:0]    addrE, wdataE;
                int              phase;
                txn_t            t;
                gntE = '0; ackE = '0; amWeE = 1'b0; ramOeE = 1'b0; ramWeE = 1'b0;
                busyE = 1'b0; dispE = 4'd0; addrE = '0; wdataE = '0; phase = -1;
                if (expQ.size() > 0) begin
                    t     = expQ[0];
                    phase = cyc - t.start;
                    gntE  = NREQ'(1) << t.owner;
                    busyE = 1'b1;
                    case (phase)
                        0: begin
                            dispE = 4'd1;
                            amWeE = 1'b1;
                            addrE = t.addr;
                        end
                        1: begin
                            dispE = 4'd2;
                            if (t.isWrite) begin
                                ramWeE = 1'b1;
                                wdataE = t.wdata;
                            end else begin
                                ramOeE = 1'b1;
                            end
                        end
                        default: begin
                            dispE = 4'd3;
                            ackE  = gntE;
                        end
                    endcase
                end
                checkOutput("port outputs {gnt,ack,amwe,oe,we,busy,state,addr,wdata}",
                            64'({gnt, ack, amWe, ramOe, ramWe, busy, dispState, memAddr, memWdata}),
                            64'({gntE, ackE, amWeE, ramOeE, ramWeE, busyE, dispE, addrE, wdataE}));
                if (phase >= 2) begin
                    if (t.isWrite) begin
                        checkOutput("ram after write", 64'(ram[t.addr[7:0]]), 64'(t.wdata));
                        shadow[t.addr[7:0]] = t.wdata;
                    end else begin
                        checkOutput("read data", 64'(rdata), 64'(shadow[t.addr[7:0]]));
                    end
                    void'(expQ.pop_front());
                end
            end
        end
    end

    task automatic applyStimulus(int i, logic w, logic [W-1:0] a, logic [W-1:0] d);
        req[i]              = 1'b1;
        we[i]               = w;
        addrBus[i*W +: W]   = a;
        wdataBus[i*W +: W]  = d;
        pending[i]          = 1'b1;
    endtask

    // Requesters hold until ack, may drop req once in ACCESS, and may reissue right after ack.
    task automatic stepCycle();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (pending[i] && ack[i]) begin
                pending[i] = 1'b0;
                req[i]     = 1'b0;
            end else if (pending[i] && req[i] && gnt[i] && dispState == 4'd2 &&
                         $urandom_range(99) < dropRate) begin
                req[i] = 1'b0;
            end
            if (!pending[i] && autoRate > 0 && $urandom_range(99) < autoRate) begin
                applyStimulus(i, 1'($urandom_range(1)), 16'($urandom_range(255)), 16'($urandom));
            end
        end
    endtask

    function automatic bit anyPending();
        bit r;
        r = 1'b0;
        for (int i = 0; i < NREQ; i++) r |= pending[i];
        return r;
    endfunction

    task automatic waitIdle(int bound);
        int n;
        n = 0;
        while (anyPending() && n < bound) begin
            stepCycle();
            n++;
        end
        checkCount++;
        if (anyPending()) begin
            failCount++;
            $display("[TB] FAIL completion timeout: requests still pending after %0d cycles, required none", bound);
            for (int i = 0; i < NREQ; i++) begin
                pending[i] = 1'b0;
                req[i]     = 1'b0;
            end
        end
        repeat (2) stepCycle();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) pending[i] = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset outputs", 64'({gnt, ack, amWe, ramOe, ramWe, busy, dispState, memAddr, memWdata}), 64'd0);
        checkOutput("reset rdata", 64'(rdata), 64'd0);
        rst_n = 1'b1;

        $display("[TB] single read");
        applyStimulus(0, 1'b0, 16'h0012, 16'h0000);
        waitIdle(20);

        $display("[TB] single write");
        applyStimulus(2, 1'b1, 16'h0030, 16'h1234);
        waitIdle(20);
        checkOutput("RAM[0x30]", 64'(ram[8'h30]), 64'h1234);

        $display("[TB] contention from reset");
        for (int i = 0; i < NREQ; i++) applyStimulus(i, 1'($urandom_range(1)), 16'($urandom_range(255)), 16'($urandom));
        doReset();
        autoRate = 100;
        repeat (40) stepCycle();
        autoRate = 0;
        waitIdle(40);

        $display("[TB] early drop");
        dropRate = 100;
        applyStimulus(1, 1'b0, 16'h0044, 16'h0000);
        waitIdle(20);
        dropRate = 0;

        $display("[TB] random traffic");
        autoRate = 30;
        dropRate = 20;
        repeat (600) stepCycle();
        autoRate = 0;
        waitIdle(60);

        $display("[TB] reset during ACCESS");
        applyStimulus(3, 1'b1, 16'h0077, 16'hA5A5);
        begin
            int n;
            n = 0;
            while (dispState != 4'd2 && n < 20) begin
                stepCycle();
                n++;
            end
            checkOutput("reach ACCESS", 64'(dispState), 64'd2);
        end
        #2 rst_n = 1'b0;
        #1 checkOutput("async reset outputs",
                       64'({gnt, ack, amWe, ramOe, ramWe, busy, dispState, memAddr, memWdata}), 64'd0);
        checkOutput("async reset rdata", 64'(rdata), 64'd0);
        for (int i = 0; i < NREQ; i++) begin
            pending[i] = 1'b0;
            req[i]     = 1'b0;
        end
        repeat (2) @(negedge clk);
        checkOutput("reset hold no ack", 64'({ack, busy}), 64'd0);
        rst_n = 1'b1;
        applyStimulus(1, 1'b0, 16'h0077, 16'h0000);
        applyStimulus(3, 1'b0, 16'h0012, 16'h0000);
        waitIdle(30);

        autoRate = 40;
        dropRate = 10;
        repeat (300) stepCycle();
        autoRate = 0;
        waitIdle(60);

`ifdef MEM_ARB_LOCK_EN
        $display("[TB] locked burst");
        sbEnable = 1'b0;
        lock[3] = 1'b1;
        applyStimulus(3, 1'b0, 16'h0012, 16'h0000);
        doReset();
        begin
            int ackCyc [3];
            int ack3;
            int ack0Cyc;
            ack3 = 0;
            ack0Cyc = -1;
            for (int k = 0; k < 3; k++) ackCyc[k] = -100;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (ack[3]) begin
                    if (ack3 < 3) ackCyc[ack3] = c;
                    ack3++;
                    if (ack3 >= 3) req[3] = 1'b0;
                end
                if (ack[0] && ack0Cyc < 0) begin
                    ack0Cyc = c;
                    req[0]  = 1'b0;
                end
                if (ack3 == 2 && dispState == 4'd1) lock[3] = 1'b0;
                if (c == 1) applyStimulus(0, 1'b0, 16'h0030, 16'h0000);
            end
            checkOutput("lock burst ack count", 64'(ack3), 64'd3);
            checkOutput("lock ack spacing 1", 64'(ackCyc[1] - ackCyc[0]), 64'd3);
            checkOutput("lock ack spacing 2", 64'(ackCyc[2] - ackCyc[1]), 64'd3);
            checkOutput("requester 0 after unlock", 64'(ack0Cyc - ackCyc[2]), 64'd4);
        end
        for (int i = 0; i < NREQ; i++) begin
            pending[i] = 1'b0;
            req[i]     = 1'b0;
        end
        lock = '0;
        doReset();
        sbEnable = 1'b1;
        repeat (4) @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
